// File: rtl/etaiim_pipe_adder.sv
// etaiim_pipe_adder: 2-stage pipelined ETA-II (modified) adder with valid/ready.
// Define ETAIIM_ERRDET_EN to add the exact-reference err flag and err_cnt.
module etaiim_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int BLK   = 4,
  parameter int CHAIN = 3,
  parameter int ECW   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             exact_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             err,
  output logic [ECW-1:0]   err_cnt
);

  localparam int NB = WIDTH / BLK;
  localparam int P  = NB - 1 - CHAIN;
  localparam int TL = (NB - 1) * BLK;

  if ((WIDTH % BLK) != 0 || CHAIN < 0 || CHAIN > NB - 1) begin : g_bad_cfg
    $error("etaiim_pipe_adder: bad WIDTH/BLK/CHAIN");
  end

  logic             s1_ld;
  logic             s2_ld;
  logic             s1_v;
  logic             s2_v;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_em;
  logic [NB-1:0]    cin_d;
  logic [NB-1:0]    s1_cin;

  assign s2_ld     = !s2_v || out_ready;
  assign s1_ld     = !s1_v || s2_ld;
  assign in_ready  = s1_ld;
  assign out_valid = s2_v;

  // Carry of a limited look-back span: overflow iff wrapped sum < a.
  assign cin_d[0] = 1'b0;
  for (genvar i = 1; i < NB; i++) begin : g_cgen
    localparam int LO = ((i - 1) >= P) ? P * BLK : (i - 1) * BLK;
    localparam int HI = i * BLK - 1;
    logic [HI-LO:0] span;
    assign span     = a[HI:LO] + b[HI:LO];
    assign cin_d[i] = span < a[HI:LO];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_em  <= 1'b0;
      s1_cin <= '0;
    end else if (s1_ld) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_a   <= a;
        s1_b   <= b;
        s1_em  <= exact_mode;
        s1_cin <= cin_d;
      end
    end
  end

  logic [WIDTH-1:0] apx_sum;
  logic             apx_co;
  logic [WIDTH:0]   ex_full;
  logic [WIDTH:0]   res_d;

  for (genvar i = 0; i < NB - 1; i++) begin : g_blk
    assign apx_sum[i*BLK +: BLK] =
      s1_a[i*BLK +: BLK] + s1_b[i*BLK +: BLK]
      + {{(BLK-1){1'b0}}, s1_cin[i]};
  end

  assign {apx_co, apx_sum[WIDTH-1:TL]} =
    {1'b0, s1_a[WIDTH-1:TL]} + {1'b0, s1_b[WIDTH-1:TL]}
    + {{BLK{1'b0}}, s1_cin[NB-1]};

  assign ex_full = {1'b0, s1_a} + {1'b0, s1_b};
  assign res_d   = s1_em ? ex_full : {apx_co, apx_sum};

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
    end else if (s2_ld) begin
      s2_v <= s1_v;
      if (s1_v) begin
        {cout, sum} <= res_d;
      end
    end
  end

`ifdef ETAIIM_ERRDET_EN
  logic err_d;
  assign err_d = res_d != ex_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (s2_ld && s1_v) begin
      err <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (s2_v && out_ready && err
                 && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ECW'(1);
    end
  end
`else
  assign err     = 1'b0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_etaiim_pipe_adder.sv
// tb_etaiim_pipe_adder: directed vectors, scoreboard model, per-cycle compare.
// Model computes block carries from plain integer arithmetic on spans.
module tb_etaiim_pipe_adder;
  localparam int W     = 32;
  localparam int BLK   = 4;
  localparam int CHAIN = 3;
  localparam int ECW   = 16;
  localparam int NB    = W / BLK;
  localparam int P     = NB - 1 - CHAIN;
`ifdef ETAIIM_ERRDET_EN
  localparam bit ERRDET = 1'b1;
`else
  localparam bit ERRDET = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           exact_mode = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   sum;
  logic           cout;
  logic           err;
  logic [ECW-1:0] err_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  etaiim_pipe_adder #(
    .WIDTH(W), .BLK(BLK), .CHAIN(CHAIN), .ECW(ECW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .exact_mode(exact_mode), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .err(err), .err_cnt(err_cnt)
  );

  function automatic logic [W:0] model(input logic [W-1:0] x,
                                       input logic [W-1:0] y,
                                       input logic em);
    longint unsigned xs, ys, r, c, lo, wd, m, blk;
    xs = 64'(x);
    ys = 64'(y);
    if (em) return W'(0) + 33'(xs + ys);
    r = 0;
    for (int i = 0; i < NB; i++) begin
      c = 0;
      if (i > 0) begin
        lo = (i - 1 >= P) ? 64'(P * BLK) : 64'((i - 1) * BLK);
        wd = 64'(i * BLK) - lo;
        m  = (64'd1 << wd) - 1;
        c  = (((xs >> lo) & m) + ((ys >> lo) & m)) >> wd;
      end
      blk = ((xs >> (i * BLK)) & 15) + ((ys >> (i * BLK)) & 15) + c;
      if (i == NB - 1) r = r | (blk << (i * BLK));
      else             r = r | ((blk & 15) << (i * BLK));
    end
    return 33'(r);
  endfunction

  function automatic logic exp_err(input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic em);
    return ERRDET && (model(x, y, em) != 33'(64'(x) + 64'(y)));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [W:0] r;
    logic       e;
  } exp_t;

  exp_t           q[$];
  int             m_cnt = 0;
  logic           hold = 1'b0;
  logic [W:0]     held;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_cnt = 0;
      hold  = 1'b0;
    end else begin
      chk("err_cnt", 64'(err_cnt), 64'(m_cnt));
      if (hold) chk("stall_hold", 64'({cout, sum}), 64'(held));
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out", 64'(out_valid), 64'(0));
        end else begin
          chk("result", 64'({err, cout, sum}),
              64'({q[0].e, q[0].r}));
          if (out_ready) begin
            if (q[0].e && m_cnt != (1 << ECW) - 1) m_cnt++;
            void'(q.pop_front());
          end
        end
      end
      hold = out_valid && !out_ready;
      held = {cout, sum};
      if (in_valid && in_ready) begin
        exp_t e;
        e.r = model(a, b, exact_mode);
        e.e = exp_err(a, b, exact_mode);
        q.push_back(e);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic em);
    in_valid   = 1'b1;
    a          = x;
    b          = y;
    exact_mode = em;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("send_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic run1(input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic em, output logic [W:0] r,
                      output logic e);
    bit got;
    got = 1'b0;
    r   = '0;
    e   = 1'b0;
    send(x, y, em);
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        r   = {cout, sum};
        e   = err;
      end
    end
    if (!got) chk("run1_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 40 && !idle; k++) begin
      @(negedge clk);
      idle = !out_valid && (q.size() == 0) && !in_valid;
    end
    if (!idle) chk("idle_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] ta[8] = '{32'h0000_00F8, 32'h00FF_FF00, 32'hFFFF_FFFF,
                          32'h8000_0000, 32'h1234_5678, 32'h0F0F_0F0F,
                          32'hFFF0_0000, 32'hDEAD_BEEF};
  logic [W-1:0] tb_[8] = '{32'h0000_0008, 32'h0000_0100, 32'h0000_0001,
                           32'h8000_0000, 32'h8765_4321, 32'h0F0F_0F0F,
                           32'h0010_0000, 32'h2152_4111};

  initial begin
    logic [W:0] r;
    logic       e;
    logic       rec[5];
    time        t0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_err_cnt", 64'(err_cnt), 64'(0));

    chk("model_f_1", 64'(model(32'hF, 32'h1, 1'b0)), 64'h10);
    chk("model_ff_1", 64'(model(32'hFF, 32'h1, 1'b0)), 64'h0);
    chk("model_ff_1_ex", 64'(model(32'hFF, 32'h1, 1'b1)), 64'h100);
    chk("model_chain",
        64'(model(32'h0FFF_0000, 32'h0001_0000, 1'b0)),
        64'h1000_0000);
    chk("model_wrap_ex", 64'(model(32'hFFFF_FFFF, 32'h1, 1'b1)),
        64'h1_0000_0000);

    @(posedge clk);
    #1;
    send(32'hF, 32'h1, 1'b0);
    @(negedge clk);
    chk("lat_edge_t", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("lat_edge_t1", 64'(out_valid), 64'(1));
    chk("lit_f_1", 64'({err, cout, sum}), 64'h10);
    @(posedge clk);
    #1;

    run1(32'hFF, 32'h1, 1'b0, r, e);
    chk("lit_ff_1", 64'(r), 64'h0);
    chk("lit_ff_1_err", 64'(e), 64'(ERRDET));
    run1(32'hFF, 32'h1, 1'b1, r, e);
    chk("lit_ff_1_ex", 64'(r), 64'h100);
    chk("lit_ff_1_ex_err", 64'(e), 64'(0));
    @(negedge clk);
    chk("lit_err_cnt", 64'(err_cnt), 64'(ERRDET));
    @(posedge clk);
    #1;
    run1(32'h0FFF_0000, 32'h0001_0000, 1'b0, r, e);
    chk("lit_chain", 64'(r), 64'h1000_0000);
    chk("lit_chain_err", 64'(e), 64'(0));
    run1(32'hFFFF_FFFF, 32'h1, 1'b1, r, e);
    chk("lit_wrap_ex", 64'(r), 64'h1_0000_0000);
    wait_idle();

    t0 = $time;
    for (int k = 0; k < 8; k++) send(ta[k], tb_[k], k == 3);
    chk("b2b_cycles", 64'(($time - t0) / 10), 64'(8));
    wait_idle();

    fork
      begin
        for (int k = 0; k < 8; k++) send(tb_[k], ta[k], 1'b0);
      end
      begin
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          rec[k] = in_ready;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    chk("stall_rdy0", 64'(rec[0]), 64'(1));
    chk("stall_rdy1", 64'(rec[1]), 64'(1));
    chk("stall_rdy2", 64'(rec[2]), 64'(0));
    chk("stall_rdy3", 64'(rec[3]), 64'(0));
    chk("stall_rdy4", 64'(rec[4]), 64'(0));
    wait_idle();

    out_ready = 1'b0;
    send(32'hFF, 32'h1, 1'b0);
    send(32'h0000_00F8, 32'h8, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    chk("mid_rst_err_cnt", 64'(err_cnt), 64'(0));
    @(posedge clk);
    #1;
    run1(32'h1234_5678, 32'h1111_1111, 1'b0, r, e);
    chk("post_rst", 64'(r), 64'h2345_6789);
    wait_idle();
    chk("drain_empty", 64'(q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
